wake_multi: RTL and testbench
=============================

Name: wake_multi

Overview:
- Generalised wake controller for the word-detection back end.
- Consumes per-frame classifier results as a one-hot/multi-hot class vector over a valid/ready stream.
- Asserts wake only after a runtime-configurable number of consecutive hits of one enabled class, then holds wake for a runtime-configurable sustain length (extendable by retriggers).
- After wake ends, enters a fixed cooldown with backpressure and reports which class caused the wake.

Parameters:
- NUM_CLASSES, 3, width of the class vector (>=1).
- HIT_BW, 4, width of the hit-threshold port.
- SUSTAIN_BW, 16, width of the sustain-length port and counter.
- COOLDOWN_LEN, 64, cycles spent in COOLDOWN after WAKE; 0 skips COOLDOWN.
- CLASS_BW, max(1, $clog2(NUM_CLASSES)), width of wake_class_o (derived).

Ports:
- clk_i, input, 1, clock.
- rst_i, input, 1, asynchronous active-high reset.
- data_i, input, NUM_CLASSES, per-frame class detections.
- valid_i, input, 1, data_i/last_i valid.
- last_i, input, 1, final frame of an utterance.
- ready_o, output, 1, beat accepted when valid_i && ready_o.
- class_mask_i, input, NUM_CLASSES, enables classes that may trigger; quasi-static.
- hit_thresh_i, input, HIT_BW, consecutive hits required; 0 treated as 1.
- sustain_len_i, input, SUSTAIN_BW, wake duration in cycles; 0 treated as 1; latched on WAKE entry.
- wake_o, output, 1, high throughout WAKE.
- wake_pulse_o, output, 1, one-cycle pulse on the first cycle wake_o is high.
- wake_class_o, output, CLASS_BW, index of the triggering class; held until the next wake.

Behaviour:
- Reset (async, rst_i=1):
  - state=IDLE; all counters 0; ready_o=0.
  - wake_o=0, wake_pulse_o=0, wake_class_o=0.
  - Reset mid-WAKE drops wake_o immediately (asynchronously).
  - After release, ready_o=1 from the first clock edge.
- Accept: a beat is consumed when valid_i && ready_o at a posedge. Non-accepted cycles leave all state and counters unchanged, except the sustain and cooldown counters, which run every cycle.
- Hit: accepted beat with m = data_i & class_mask_i nonzero. Hit class = lowest set index of m.
- States:
  - IDLE (ready_o=1): on a hit, if effective threshold = 1, go to WAKE; else go to ARM with hit_cnt=1 and cand=hit class. A non-hit keeps IDLE.
  - ARM (ready_o=1):
    - Hit with class == cand: hit_cnt+1; if the new count >= effective threshold, go to WAKE.
    - Hit with a different class: restart, hit_cnt=1, cand=new class.
    - Non-hit beat: go to IDLE, hit_cnt=0.
    - Accepted beat with last_i=1 that does not cause WAKE: go to IDLE, hit_cnt=0. The beat itself is still evaluated first.
  - WAKE (ready_o=1):
    - wake_o=1. On entry: sus_cnt=0, sus_len latched, wake_class_o=cand/hit class, wake_pulse_o=1 for exactly one cycle.
    - sus_cnt increments every cycle. When sus_cnt == sus_len-1, exit to COOLDOWN, or to IDLE if COOLDOWN_LEN=0.
    - Retrigger: an accepted hit of the same class as wake_class_o resets sus_cnt to 0 and produces no new pulse. Retrigger wins over simultaneous terminal count.
    - Hits of other classes and last_i are ignored in WAKE.
  - COOLDOWN (ready_o=0): cd_cnt counts 0..COOLDOWN_LEN-1, then go to IDLE with hit_cnt=0.
- Latency: the triggering beat accepted at edge N gives wake_o=1 and wake_pulse_o=1 in the cycle after edge N.
- WAKE duration with no retrigger is exactly sus_len cycles. After COOLDOWN_LEN cycles of ready_o=0, ready_o returns to 1.
- Widths:
  - hit_cnt saturates at 2^HIT_BW-1.
  - Threshold comparison is unsigned.
  - sus_cnt is SUSTAIN_BW wide and never wraps, because terminal count is checked first.
- All outputs are registered except ready_o. ready_o is a decode of the state register.

Test Plan:
1. Threshold 3, mask=3'b001, sustain 8, COOLDOWN_LEN=4:
   - Stimulus: three consecutive valid beats of data_i=3'b001.
   - Response: wake_o rises the cycle after the third beat and stays high 8 cycles; wake_pulse_o high 1 cycle; wake_class_o=0; ready_o=0 for 4 cycles, then 1.
2. Streak broken, threshold 3, mask=3'b111:
   - Stimulus: 001, 001, 000, 001, 001.
   - Response: no wake. Repeat with 001, 001, 100, 100, 100: wake with wake_class_o=2.
3. Gaps and last_i, threshold 2:
   - Stimulus: 010 beat, 5 idle cycles with valid_i=0, then 010.
   - Response: wake (gaps do not break the streak). Repeat with last_i=1 on the first beat: no wake.
4. Retrigger, sustain 10:
   - Stimulus: triggering-class hit at WAKE cycle 6.
   - Response: total wake_o high time 16 cycles, single wake_pulse_o. A hit at exactly the terminal cycle extends wake.
5. Zero configuration:
   - Stimulus: hit_thresh_i=0, sustain_len_i=0, COOLDOWN_LEN=0.
   - Response: one hit gives wake_o high exactly 1 cycle, back to IDLE with ready_o=1 immediately. Masked-off class hits never wake.
6. Async reset:
   - Stimulus: rst_i pulsed mid-WAKE, between clock edges.
   - Response: wake_o, wake_class_o and ready_o go to 0 without waiting for a clock edge. After release, a fresh threshold-count sequence is required to wake.

Source files
------------

// File: rtl/wake_multi.sv
// Wake controller for the word-detection back end: arms on consecutive hits of one
// enabled class, holds wake for a configurable sustain time, then cools down.
module wake_multi #(
    parameter int NUM_CLASSES  = 3,
    parameter int HIT_BW       = 4,
    parameter int SUSTAIN_BW   = 16,
    parameter int COOLDOWN_LEN = 64,
    parameter int CLASS_BW     = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [NUM_CLASSES-1:0] data_i,
    input  logic                   valid_i,
    input  logic                   last_i,
    output logic                   ready_o,
    input  logic [NUM_CLASSES-1:0] class_mask_i,
    input  logic [HIT_BW-1:0]      hit_thresh_i,
    input  logic [SUSTAIN_BW-1:0]  sustain_len_i,
    output logic                   wake_o,
    output logic                   wake_pulse_o,
    output logic [CLASS_BW-1:0]    wake_class_o
);

    localparam int CD_BW = (COOLDOWN_LEN > 1) ? $clog2(COOLDOWN_LEN) : 1;
    localparam logic [HIT_BW-1:0] HIT_MAX = '1;
    localparam logic [CD_BW-1:0]  CD_LAST = CD_BW'((COOLDOWN_LEN > 0) ? (COOLDOWN_LEN - 1) : 0);

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        WAKE,
        COOLDOWN
    } state_e;

    state_e                 state_q, state_d;
    logic                   run_q, run_d;
    logic [HIT_BW-1:0]      hit_cnt_q, hit_cnt_d;
    logic [CLASS_BW-1:0]    cand_q, cand_d;
    logic [SUSTAIN_BW-1:0]  sus_cnt_q, sus_cnt_d;
    logic [SUSTAIN_BW-1:0]  sus_len_q, sus_len_d;
    logic [CD_BW-1:0]       cd_cnt_q, cd_cnt_d;
    logic                   wake_q, wake_d;
    logic                   pulse_q, pulse_d;
    logic [CLASS_BW-1:0]    class_q, class_d;

    logic [NUM_CLASSES-1:0] masked;
    logic                   hit_any;
    logic [CLASS_BW-1:0]    hit_class;
    logic                   accept;
    logic                   hit;
    logic [HIT_BW-1:0]      eff_thresh;
    logic [SUSTAIN_BW-1:0]  eff_sustain;
    logic [HIT_BW-1:0]      hit_cnt_inc;
    logic                   enter_wake;

    // run_q keeps ready_o low while reset is held and until the first edge after release
    assign ready_o      = run_q && (state_q != COOLDOWN);
    assign wake_o       = wake_q;
    assign wake_pulse_o = pulse_q;
    assign wake_class_o = class_q;

    assign masked      = data_i & class_mask_i;
    assign hit_any     = |masked;
    assign accept      = valid_i && ready_o;
    assign hit         = accept && hit_any;
    assign eff_thresh  = (hit_thresh_i == '0) ? HIT_BW'(1) : hit_thresh_i;
    assign eff_sustain = (sustain_len_i == '0) ? SUSTAIN_BW'(1) : sustain_len_i;
    assign hit_cnt_inc = (hit_cnt_q == HIT_MAX) ? HIT_MAX : (hit_cnt_q + HIT_BW'(1));

    // Lowest set index of the masked vector wins when several classes fire together
    always_comb begin
        hit_class = '0;
        for (int i = NUM_CLASSES - 1; i >= 0; i--) begin
            if (masked[i]) begin
                hit_class = CLASS_BW'(i);
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        run_d      = 1'b1;
        hit_cnt_d  = hit_cnt_q;
        cand_d     = cand_q;
        sus_cnt_d  = sus_cnt_q;
        sus_len_d  = sus_len_q;
        cd_cnt_d   = cd_cnt_q;
        class_d    = class_q;
        enter_wake = 1'b0;

        case (state_q)
            IDLE: begin
                if (hit) begin
                    if (eff_thresh == HIT_BW'(1)) begin
                        enter_wake = 1'b1;
                    end else if (!last_i) begin
                        state_d   = ARM;
                        hit_cnt_d = HIT_BW'(1);
                        cand_d    = hit_class;
                    end
                end
            end

            ARM: begin
                if (accept) begin
                    if (!hit_any) begin
                        state_d   = IDLE;
                        hit_cnt_d = '0;
                    end else if (hit_class == cand_q) begin
                        if (hit_cnt_inc >= eff_thresh) begin
                            enter_wake = 1'b1;
                        end else if (last_i) begin
                            state_d   = IDLE;
                            hit_cnt_d = '0;
                        end else begin
                            hit_cnt_d = hit_cnt_inc;
                        end
                    end else begin
                        // A different class restarts the streak from one
                        if (HIT_BW'(1) >= eff_thresh) begin
                            enter_wake = 1'b1;
                        end else if (last_i) begin
                            state_d   = IDLE;
                            hit_cnt_d = '0;
                        end else begin
                            hit_cnt_d = HIT_BW'(1);
                            cand_d    = hit_class;
                        end
                    end
                end
            end

            WAKE: begin
                // Retrigger is tested before terminal count so a hit on the last cycle extends wake
                if (hit && (hit_class == class_q)) begin
                    sus_cnt_d = '0;
                end else if (sus_cnt_q == (sus_len_q - SUSTAIN_BW'(1))) begin
                    state_d   = (COOLDOWN_LEN == 0) ? IDLE : COOLDOWN;
                    cd_cnt_d  = '0;
                    hit_cnt_d = '0;
                end else begin
                    sus_cnt_d = sus_cnt_q + SUSTAIN_BW'(1);
                end
            end

            COOLDOWN: begin
                if (cd_cnt_q == CD_LAST) begin
                    state_d   = IDLE;
                    hit_cnt_d = '0;
                end else begin
                    cd_cnt_d = cd_cnt_q + CD_BW'(1);
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        if (enter_wake) begin
            state_d   = WAKE;
            sus_cnt_d = '0;
            sus_len_d = eff_sustain;
            class_d   = hit_class;
            hit_cnt_d = '0;
        end

        wake_d  = (state_d == WAKE);
        pulse_d = enter_wake;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            run_q     <= 1'b0;
            hit_cnt_q <= '0;
            cand_q    <= '0;
            sus_cnt_q <= '0;
            sus_len_q <= '0;
            cd_cnt_q  <= '0;
            wake_q    <= 1'b0;
            pulse_q   <= 1'b0;
            class_q   <= '0;
        end else begin
            state_q   <= state_d;
            run_q     <= run_d;
            hit_cnt_q <= hit_cnt_d;
            cand_q    <= cand_d;
            sus_cnt_q <= sus_cnt_d;
            sus_len_q <= sus_len_d;
            cd_cnt_q  <= cd_cnt_d;
            wake_q    <= wake_d;
            pulse_q   <= pulse_d;
            class_q   <= class_d;
        end
    end

endmodule

// File: tb/tb_wake_multi.sv
// Directed bench for wake_multi: one instance with a 4-cycle cooldown, one with none.
module tb_wake_multi;

   logic        clock;
   logic        reset;
   logic [2:0]  data;
   logic        validA;
   logic        validZ;
   logic        last;
   logic [2:0]  mask;
   logic [3:0]  thresh;
   logic [15:0] sustain;

   logic        readyA, wakeA, pulseA;
   logic [1:0]  classA;
   logic        readyZ, wakeZ, pulseZ;
   logic [1:0]  classZ;

   int checks = 0;
   int errors = 0;
   int len;
   int pulses;
   int cdCycles;

   wake_multi #(.NUM_CLASSES(3), .HIT_BW(4), .SUSTAIN_BW(16), .COOLDOWN_LEN(4)) dutA (
      .clk_i(clock), .rst_i(reset), .data_i(data), .valid_i(validA), .last_i(last),
      .ready_o(readyA), .class_mask_i(mask), .hit_thresh_i(thresh), .sustain_len_i(sustain),
      .wake_o(wakeA), .wake_pulse_o(pulseA), .wake_class_o(classA)
   );

   wake_multi #(.NUM_CLASSES(3), .HIT_BW(4), .SUSTAIN_BW(16), .COOLDOWN_LEN(0)) dutZ (
      .clk_i(clock), .rst_i(reset), .data_i(data), .valid_i(validZ), .last_i(last),
      .ready_o(readyZ), .class_mask_i(mask), .hit_thresh_i(thresh), .sustain_len_i(sustain),
      .wake_o(wakeZ), .wake_pulse_o(pulseZ), .wake_class_o(classZ)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Hard stop so a stuck run still reports a failure
   initial begin
      #200000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic tick;
      @(posedge clock);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input int sel, input logic [2:0] d, input logic l);
      data = d;
      last = l;
      if (sel == 0) validA = 1'b1;
      else          validZ = 1'b1;
      tick();
      validA = 1'b0;
      validZ = 1'b0;
      last   = 1'b0;
      data   = '0;
   endtask

   // Counts wake cycles from the current sample point, optionally injecting one beat in cycle retrigCycle
   task automatic measureWake(input int sel, input int retrigCycle, input logic [2:0] retrigData,
                              output int wakeLen, output int pulseCount);
      int guard;
      wakeLen    = 0;
      pulseCount = 0;
      guard      = 0;
      while (((sel == 0) ? wakeA : wakeZ) && guard < 300) begin
         wakeLen++;
         pulseCount += int'((sel == 0) ? pulseA : pulseZ);
         if (wakeLen == retrigCycle) begin
            data = retrigData;
            if (sel == 0) validA = 1'b1;
            else          validZ = 1'b1;
         end
         tick();
         validA = 1'b0;
         validZ = 1'b0;
         data   = '0;
         guard++;
      end
   endtask

   task automatic waitReady(output int cycles);
      int guard;
      cycles = 0;
      guard  = 0;
      while (!readyA && guard < 300) begin
         cycles++;
         tick();
         guard++;
      end
   endtask

   initial begin
      reset   = 1'b1;
      data    = '0;
      validA  = 1'b0;
      validZ  = 1'b0;
      last    = 1'b0;
      mask    = 3'b001;
      thresh  = 4'd3;
      sustain = 16'd8;

      #3;
      checkOutput("rst_ready", readyA, 1'b0);
      checkOutput("rst_wake", wakeA, 1'b0);
      checkOutput("rst_pulse", pulseA, 1'b0);
      checkOutput("rst_class", classA, 2'd0);
      tick();
      reset = 1'b0;
      checkOutput("rel_ready_pre_edge", readyA, 1'b0);
      tick();
      checkOutput("rel_ready_a", readyA, 1'b1);
      checkOutput("rel_ready_z", readyZ, 1'b1);

      $display("[TB] test 1: threshold 3, sustain 8, cooldown 4");
      applyStimulus(0, 3'b001, 1'b0);
      checkOutput("t1_beat1", wakeA, 1'b0);
      applyStimulus(0, 3'b001, 1'b0);
      checkOutput("t1_beat2", wakeA, 1'b0);
      applyStimulus(0, 3'b001, 1'b0);
      checkOutput("t1_wake", wakeA, 1'b1);
      checkOutput("t1_pulse", pulseA, 1'b1);
      checkOutput("t1_class", classA, 2'd0);
      measureWake(0, 0, 3'b000, len, pulses);
      checkOutput("t1_len", len, 8);
      checkOutput("t1_pulses", pulses, 1);
      checkOutput("t1_cd_ready", readyA, 1'b0);
      waitReady(cdCycles);
      checkOutput("t1_cd_len", cdCycles, 4);

      $display("[TB] test 2: broken streak and class switch");
      mask = 3'b111;
      applyStimulus(0, 3'b001, 1'b0);
      applyStimulus(0, 3'b001, 1'b0);
      applyStimulus(0, 3'b000, 1'b0);
      applyStimulus(0, 3'b001, 1'b0);
      applyStimulus(0, 3'b001, 1'b0);
      checkOutput("t2_broken", wakeA, 1'b0);
      applyStimulus(0, 3'b000, 1'b0);
      applyStimulus(0, 3'b001, 1'b0);
      applyStimulus(0, 3'b001, 1'b0);
      applyStimulus(0, 3'b100, 1'b0);
      applyStimulus(0, 3'b100, 1'b0);
      checkOutput("t2_switch_no_wake", wakeA, 1'b0);
      applyStimulus(0, 3'b100, 1'b0);
      checkOutput("t2_wake", wakeA, 1'b1);
      checkOutput("t2_class", classA, 2'd2);
      measureWake(0, 0, 3'b000, len, pulses);
      checkOutput("t2_len", len, 8);
      waitReady(cdCycles);
      checkOutput("t2_cd_len", cdCycles, 4);

      $display("[TB] test 3: gaps and last");
      thresh = 4'd2;
      applyStimulus(0, 3'b010, 1'b0);
      for (int i = 0; i < 5; i++) tick();
      checkOutput("t3_gap_no_wake", wakeA, 1'b0);
      applyStimulus(0, 3'b010, 1'b0);
      checkOutput("t3_wake", wakeA, 1'b1);
      checkOutput("t3_class", classA, 2'd1);
      measureWake(0, 0, 3'b000, len, pulses);
      waitReady(cdCycles);
      applyStimulus(0, 3'b010, 1'b1);
      for (int i = 0; i < 5; i++) tick();
      applyStimulus(0, 3'b010, 1'b0);
      checkOutput("t3_last_no_wake", wakeA, 1'b0);
      applyStimulus(0, 3'b000, 1'b0);

      $display("[TB] test 4: retrigger");
      sustain = 16'd10;
      applyStimulus(0, 3'b010, 1'b0);
      applyStimulus(0, 3'b010, 1'b0);
      measureWake(0, 6, 3'b010, len, pulses);
      checkOutput("t4_retrig_len", len, 16);
      checkOutput("t4_retrig_pulses", pulses, 1);
      waitReady(cdCycles);
      applyStimulus(0, 3'b010, 1'b0);
      applyStimulus(0, 3'b010, 1'b0);
      measureWake(0, 10, 3'b010, len, pulses);
      checkOutput("t4_terminal_len", len, 20);
      checkOutput("t4_terminal_pulses", pulses, 1);
      waitReady(cdCycles);
      applyStimulus(0, 3'b010, 1'b0);
      applyStimulus(0, 3'b010, 1'b0);
      measureWake(0, 6, 3'b001, len, pulses);
      checkOutput("t4_other_class_len", len, 10);
      waitReady(cdCycles);
      checkOutput("t4_class_held", classA, 2'd1);

      $display("[TB] test 5: zero configuration");
      thresh  = 4'd0;
      sustain = 16'd0;
      mask    = 3'b111;
      applyStimulus(1, 3'b100, 1'b0);
      checkOutput("t5_wake", wakeZ, 1'b1);
      checkOutput("t5_pulse", pulseZ, 1'b1);
      checkOutput("t5_class", classZ, 2'd2);
      measureWake(1, 0, 3'b000, len, pulses);
      checkOutput("t5_len", len, 1);
      checkOutput("t5_ready", readyZ, 1'b1);
      mask = 3'b011;
      applyStimulus(1, 3'b100, 1'b0);
      applyStimulus(1, 3'b100, 1'b0);
      checkOutput("t5_masked", wakeZ, 1'b0);
      checkOutput("t5_class_held", classZ, 2'd2);

      $display("[TB] test 6: async reset mid-wake");
      thresh  = 4'd2;
      sustain = 16'd8;
      mask    = 3'b100;
      applyStimulus(0, 3'b100, 1'b0);
      applyStimulus(0, 3'b100, 1'b0);
      checkOutput("t6_wake", wakeA, 1'b1);
      checkOutput("t6_class", classA, 2'd2);
      tick();
      tick();
      #2;
      reset = 1'b1;
      #1;
      checkOutput("t6_rst_wake", wakeA, 1'b0);
      checkOutput("t6_rst_class", classA, 2'd0);
      checkOutput("t6_rst_ready", readyA, 1'b0);
      #1;
      reset = 1'b0;
      tick();
      checkOutput("t6_rel_ready", readyA, 1'b1);
      applyStimulus(0, 3'b100, 1'b0);
      checkOutput("t6_first_beat", wakeA, 1'b0);
      applyStimulus(0, 3'b100, 1'b0);
      checkOutput("t6_rewake", wakeA, 1'b1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
